// File: rtl/access_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : access_monitor                                                |
// | Purpose  : Passive observer of the 3-master access controller. Counts    |
// |            grants per master and M1 preemptions of M2/M3, watches how    |
// |            long one owner holds the bus, flags starving requesters and   |
// |            done strobes from masters that do not own the bus.            |
// | Ports    : clk, reset (sync, active-high)                                |
// |            req[2:0], done[2:0]   bit0=M1, bit1=M2, bit2=M3               |
// |            accmodule[1:0]        current owner, 0=none, 1..3=M1..M3      |
// |            clr_stats             clears counters and sticky flags        |
// |            grant_cnt_m1/m2/m3    saturating grant counters               |
// |            int_cnt               saturating M1 preemption counter        |
// |            wdog_pulse/sticky     hold-limit watchdog pulse and flag      |
// |            wdog_module           owner code of the last watchdog trip    |
// |            starve[2:0]           sticky starvation flags                 |
// |            proto_err             sticky done-from-non-owner flag         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module access_monitor #(
  parameter int CNT_W      = 16,
  parameter int MAX_HOLD   = 64,
  parameter int STARVE_LIM = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [2:0]       done,
  input  logic [1:0]       accmodule,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] grant_cnt_m1,
  output logic [CNT_W-1:0] grant_cnt_m2,
  output logic [CNT_W-1:0] grant_cnt_m3,
  output logic [CNT_W-1:0] int_cnt,
  output logic             wdog_pulse,
  output logic             wdog_sticky,
  output logic [1:0]       wdog_module,
  output logic [2:0]       starve,
  output logic             proto_err
);

  localparam int c_hold_w = $clog2(MAX_HOLD + 1);
  localparam int c_wait_w = $clog2(STARVE_LIM + 1);
  localparam logic [c_hold_w-1:0] c_hold_trip = c_hold_w'(MAX_HOLD - 1);
  localparam logic [c_hold_w-1:0] c_hold_max  = '1;
  localparam logic [c_wait_w-1:0] c_wait_lim  = c_wait_w'(STARVE_LIM);
  localparam logic [CNT_W-1:0]    c_cnt_max   = '1;

  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_OWNED = 2'd1,
    MON_TRIP  = 2'd2
  } mon_state_e;

  mon_state_e          state_q, state_d;
  logic [1:0]          prev_owner_q, prev_owner_d;
  // Only M2/M3 completion matters for preemption detection.
  logic [2:1]          prev_done_q, prev_done_d;
  logic [c_hold_w-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]    grant_q [3];
  logic [CNT_W-1:0]    grant_d [3];
  logic [CNT_W-1:0]    int_q, int_d;
  logic [c_wait_w-1:0] wait_q [3];
  logic [c_wait_w-1:0] wait_d [3];
  logic                wdog_pulse_q, wdog_pulse_d;
  logic                wdog_sticky_q, wdog_sticky_d;
  logic [1:0]          wdog_module_q, wdog_module_d;
  logic [2:0]          starve_q, starve_d;
  logic                proto_err_q, proto_err_d;
  logic [2:0]          starve_hit;
  logic [2:0]          done_bad;

  logic w_new_owner;
  logic w_same_owner;
  logic w_prev_owner_done;
  logic w_int_evt;
  logic w_trip;

  assign w_new_owner  = (accmodule != 2'd0) && (accmodule != prev_owner_q);
  assign w_same_owner = (accmodule != 2'd0) && (accmodule == prev_owner_q);
  // prev_owner_q is 2 or 3 whenever this term matters; bit0 selects M3.
  assign w_prev_owner_done = prev_owner_q[0] ? prev_done_q[2] : prev_done_q[1];
  // M1 taking the bus from M2/M3 that had not signalled completion.
  assign w_int_evt = (accmodule == 2'd1) && prev_owner_q[1] && !w_prev_owner_done;
  // hold_d counts owned cycles minus one, so this fires on the
  // MAX_HOLD-th consecutive cycle of the same owner.
  assign w_trip = (state_q == MON_OWNED) && w_same_owner && (hold_d == c_hold_trip);

  // Owner tracking and hold counter.
  always_comb begin
    prev_owner_d = accmodule;
    prev_done_d  = done[2:1];
    hold_d       = '0;
    if (w_same_owner) begin
      hold_d = (hold_q == c_hold_max) ? hold_q : hold_q + 1'b1;
    end
  end

  // Watchdog FSM and its outputs.
  always_comb begin
    state_d       = state_q;
    wdog_pulse_d  = w_trip;
    wdog_sticky_d = w_trip | (wdog_sticky_q & ~clr_stats);
    wdog_module_d = clr_stats ? 2'd0 : wdog_module_q;
    if (w_trip) begin
      wdog_module_d = accmodule;
    end
    unique case (state_q)
      MON_IDLE: begin
        if (accmodule != 2'd0) state_d = MON_OWNED;
      end
      MON_OWNED: begin
        if (accmodule == 2'd0) state_d = MON_IDLE;
        else if (w_trip)       state_d = MON_TRIP;
      end
      MON_TRIP: begin
        if (accmodule == 2'd0) state_d = MON_IDLE;
        else if (w_new_owner)  state_d = MON_OWNED;
      end
      default: state_d = MON_IDLE;
    endcase
  end

  // Statistics counters, starvation and protocol checks.
  always_comb begin
    starve_hit = '0;
    done_bad   = '0;
    for (int i = 0; i < 3; i++) begin
      grant_d[i] = grant_q[i];
      if (clr_stats) begin
        grant_d[i] = '0;
      end else if (w_new_owner && (accmodule == 2'(i + 1)) && (grant_q[i] != c_cnt_max)) begin
        grant_d[i] = grant_q[i] + 1'b1;
      end
      wait_d[i] = '0;
      if (req[i] && (accmodule != 2'(i + 1))) begin
        wait_d[i] = (wait_q[i] == c_wait_lim) ? wait_q[i] : wait_q[i] + 1'b1;
      end
      starve_hit[i] = (wait_d[i] == c_wait_lim);
      done_bad[i]   = done[i] && (accmodule != 2'(i + 1));
    end
    int_d = int_q;
    if (clr_stats) begin
      int_d = '0;
    end else if (w_int_evt && (int_q != c_cnt_max)) begin
      int_d = int_q + 1'b1;
    end
    // A new set event survives a simultaneous clear.
    starve_d    = starve_hit | (clr_stats ? 3'b000 : starve_q);
    proto_err_d = (|done_bad) | (proto_err_q & ~clr_stats);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= MON_IDLE;
      prev_owner_q  <= '0;
      prev_done_q   <= '0;
      hold_q        <= '0;
      int_q         <= '0;
      wdog_pulse_q  <= 1'b0;
      wdog_sticky_q <= 1'b0;
      wdog_module_q <= '0;
      starve_q      <= '0;
      proto_err_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        grant_q[i] <= '0;
        wait_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      prev_owner_q  <= prev_owner_d;
      prev_done_q   <= prev_done_d;
      hold_q        <= hold_d;
      int_q         <= int_d;
      wdog_pulse_q  <= wdog_pulse_d;
      wdog_sticky_q <= wdog_sticky_d;
      wdog_module_q <= wdog_module_d;
      starve_q      <= starve_d;
      proto_err_q   <= proto_err_d;
      for (int i = 0; i < 3; i++) begin
        grant_q[i] <= grant_d[i];
        wait_q[i]  <= wait_d[i];
      end
    end
  end

  assign grant_cnt_m1 = grant_q[0];
  assign grant_cnt_m2 = grant_q[1];
  assign grant_cnt_m3 = grant_q[2];
  assign int_cnt      = int_q;
  assign wdog_pulse   = wdog_pulse_q;
  assign wdog_sticky  = wdog_sticky_q;
  assign wdog_module  = wdog_module_q;
  assign starve       = starve_q;
  assign proto_err    = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_access_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_access_monitor                                             |
// | Purpose  : Scoreboard bench for access_monitor. A driver applies one     |
// |            input vector per cycle and pushes the expected outputs from   |
// |            a behavioural model; a monitor pops and compares after each   |
// |            rising edge.                                                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_access_monitor;

  localparam int CW   = 2;
  localparam int HOLD = 4;
  localparam int SLIM = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    req;
  logic [2:0]    done;
  logic [1:0]    accmodule;
  logic          clr_stats;
  logic [CW-1:0] grant_cnt_m1, grant_cnt_m2, grant_cnt_m3, int_cnt;
  logic          wdog_pulse, wdog_sticky;
  logic [1:0]    wdog_module;
  logic [2:0]    starve;
  logic          proto_err;

  access_monitor #(.CNT_W(CW), .MAX_HOLD(HOLD), .STARVE_LIM(SLIM)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .done         (done),
    .accmodule    (accmodule),
    .clr_stats    (clr_stats),
    .grant_cnt_m1 (grant_cnt_m1),
    .grant_cnt_m2 (grant_cnt_m2),
    .grant_cnt_m3 (grant_cnt_m3),
    .int_cnt      (int_cnt),
    .wdog_pulse   (wdog_pulse),
    .wdog_sticky  (wdog_sticky),
    .wdog_module  (wdog_module),
    .starve       (starve),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] g1, g2, g3, ic;
    logic       pulse, sticky;
    logic [1:0] wmod;
    logic [2:0] stv;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state (history-based, not register-level).
  int       m_prev;
  int       m_run;
  int       m_g[3];
  int       m_ic;
  int       m_wait[3];
  bit [2:0] m_prev_done;
  bit       m_sticky;
  int       m_mod;
  bit [2:0] m_starve;
  bit       m_perr;

  task automatic model_reset();
    m_prev = 0; m_run = 0; m_ic = 0; m_prev_done = '0;
    m_sticky = 0; m_mod = 0; m_starve = '0; m_perr = 0;
    for (int i = 0; i < 3; i++) begin
      m_g[i] = 0;
      m_wait[i] = 0;
    end
  endtask

  task automatic model_step(input bit r, input bit [2:0] rq, input bit [2:0] dn,
                            input int a, input bit cl, output exp_t e);
    bit pulse;
    bit intr;
    bit bad;
    pulse = 0;
    if (r) begin
      model_reset();
    end else begin
      // Length of the current uninterrupted ownership run.
      if (a == 0) m_run = 0;
      else if (a != m_prev) m_run = 1;
      else m_run = m_run + 1;
      pulse = (a != 0) && (m_run == HOLD);

      for (int i = 0; i < 3; i++) begin
        if (cl) m_g[i] = 0;
        else if (a == i + 1 && a != m_prev && m_g[i] < CMAX) m_g[i] = m_g[i] + 1;
      end

      intr = 0;
      if (a == 1 && (m_prev == 2 || m_prev == 3)) intr = !m_prev_done[m_prev - 1];
      if (cl) m_ic = 0;
      else if (intr && m_ic < CMAX) m_ic = m_ic + 1;

      m_sticky = pulse || (m_sticky && !cl);
      if (pulse) m_mod = a;
      else if (cl) m_mod = 0;

      if (cl) m_starve = '0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
        if (rq[i] && a != i + 1) m_wait[i] = m_wait[i] + 1;
        else m_wait[i] = 0;
        if (m_wait[i] >= SLIM) m_starve[i] = 1'b1;
        if (dn[i] && a != i + 1) bad = 1;
      end
      m_perr = bad || (m_perr && !cl);

      m_prev = a;
      m_prev_done = dn;
    end
    e.g1 = 8'(m_g[0]); e.g2 = 8'(m_g[1]); e.g3 = 8'(m_g[2]); e.ic = 8'(m_ic);
    e.pulse = pulse; e.sticky = m_sticky; e.wmod = 2'(m_mod);
    e.stv = m_starve; e.perr = m_perr;
  endtask

  task automatic drive(input bit r, input bit [2:0] rq, input bit [2:0] dn,
                       input int a, input bit cl);
    exp_t e;
    @(negedge clk);
    reset = r; req = rq; done = dn; accmodule = 2'(a); clr_stats = cl;
    model_step(r, rq, dn, a, cl, e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
    end
  endtask

  // Monitor: outputs are valid every cycle, one expected entry per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant_cnt_m1", 8'(grant_cnt_m1), e.g1);
        check("grant_cnt_m2", 8'(grant_cnt_m2), e.g2);
        check("grant_cnt_m3", 8'(grant_cnt_m3), e.g3);
        check("int_cnt",      8'(int_cnt),      e.ic);
        check("wdog_pulse",   8'(wdog_pulse),   8'(e.pulse));
        check("wdog_sticky",  8'(wdog_sticky),  8'(e.sticky));
        check("wdog_module",  8'(wdog_module),  8'(e.wmod));
        check("starve",       8'(starve),       8'(e.stv));
        check("proto_err",    8'(proto_err),    8'(e.perr));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int owner, len;
    bit [2:0] rq, dn;
    bit r, cl;
    reset = 1'b1; req = '0; done = '0; accmodule = '0; clr_stats = 1'b0;
    model_reset();

    // Reset with idle bus.
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    // M2 owns for 3 cycles, completes on the last one.
    drive(0, 0, 0, 2, 0);
    drive(0, 0, 0, 2, 0);
    drive(0, 0, 3'b010, 2, 0);
    drive(0, 0, 0, 0, 0);
    // M3 preempted by M1 without done.
    drive(0, 0, 0, 3, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    // M2 done then M1: no preemption.
    drive(0, 0, 3'b010, 2, 0);
    drive(0, 0, 0, 1, 0);
    // Long M1 hold: single watchdog pulse.
    drive(0, 0, 0, 0, 1);
    for (int k = 0; k < 10; k++) drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    // Starvation of M3 and done from a non-owner.
    drive(0, 0, 0, 0, 1);
    for (int k = 0; k < SLIM; k++) drive(0, 3'b100, 0, 1, 0);
    drive(0, 0, 3'b010, 1, 0);
    // Counter saturation, clear, and reset mid-grant.
    drive(0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 2, 0);
      drive(0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 2, 0);
    drive(1, 0, 0, 2, 0);
    drive(0, 0, 0, 2, 0);
    drive(0, 0, 0, 2, 1);

    // Randomised ownership bursts.
    for (int b = 0; b < 300; b++) begin
      owner = $urandom_range(0, 3);
      len   = $urandom_range(1, 8);
      rq    = 3'($urandom);
      for (int k = 0; k < len; k++) begin
        r  = ($urandom_range(0, 99) == 0);
        cl = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 7) == 0) rq = 3'($urandom);
        dn = '0;
        if (owner != 0 && k == len - 1 && $urandom_range(0, 1) == 1) dn[owner - 1] = 1'b1;
        if ($urandom_range(0, 39) == 0) dn = 3'($urandom);
        drive(r, rq, dn, owner, cl);
      end
    end

    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
